// File: rtl/serial_add_sched.sv
// Round-robin scheduler that time-shares one external 1-bit full adder between two
// requesters, running each WIDTH-bit addition LSB first and returning a tagged response.
module serial_add_sched #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             NRST,
    input  logic             clr,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             req1_ready,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    input  logic             rsp_ready,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             last_grant;
    logic             grant;
    logic             accept;
    logic             last_bit;

    // Alternate only on contention; a lone requester always wins.
    assign grant    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign accept   = (state == IDLE) && !clr && (req0_valid || req1_valid);
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign rsp_sum  = sum_sh;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nx = RUN;
                RUN:     if (last_bit) state_nx = DONE;
                DONE:    if (rsp_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        fa_a       = 1'b0;
        fa_b       = 1'b0;
        fa_cin     = 1'b0;
        if (state == RUN) begin
            fa_a   = a_sh[0];
            fa_b   = b_sh[0];
            fa_cin = carry;
        end
        rsp_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            a_sh       <= '0;
            b_sh       <= '0;
            sum_sh     <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_cout   <= 1'b0;
            last_grant <= 1'b1;
        end else if (clr) begin
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_sh       <= grant ? req1_a : req0_a;
                    b_sh       <= grant ? req1_b : req0_b;
                    carry      <= grant ? req1_cin : req0_cin;
                    cnt        <= '0;
                    rsp_id     <= grant;
                    last_grant <= grant;
                end
                RUN: begin
                    // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
                    carry  <= fa_cout;
                    sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) rsp_cout <= fa_cout;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sched.sv
// Randomised and directed bench for serial_add_sched; a transaction-level model
// predicts every output each cycle from the request/response rules and plain addition.
module tb_serial_add_sched;
    localparam int W = 8;

    logic         CLK = 0;
    logic         NRST;
    logic         clr;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin;
    logic         req0_ready, req1_ready;
    logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic         rsp_valid, rsp_id, rsp_cout, rsp_ready, busy;
    logic [W-1:0] rsp_sum;

    int checks = 0;
    int errors = 0;

    serial_add_sched #(.WIDTH(W)) dut (
        .CLK(CLK), .NRST(NRST), .clr(clr),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_ready(req1_ready),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_ready(rsp_ready), .busy(busy)
    );

    // The shared external full adder.
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_age = -1 idle, 0..W-1 = index of bit being added, W = response waiting.
    int           m_age;
    logic [W-1:0] m_a, m_b;
    logic         m_cin, m_id, m_last;

    function automatic logic [1:0] m_ready();
        logic g;
        if (m_age != -1 || clr || !(req0_valid || req1_valid)) return 2'b00;
        g = (req0_valid && req1_valid) ? !m_last : req1_valid;
        return g ? 2'b10 : 2'b01;
    endfunction

    always @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            m_age  <= -1;
            m_id   <= 1'b0;
            m_last <= 1'b1;
        end else if (clr) begin
            m_age <= -1;
        end else if (m_age == -1) begin
            if (m_ready() != 2'b00) begin
                m_age  <= 0;
                m_id   <= m_ready() == 2'b10;
                m_last <= m_ready() == 2'b10;
                m_a    <= (m_ready() == 2'b10) ? req1_a : req0_a;
                m_b    <= (m_ready() == 2'b10) ? req1_b : req0_b;
                m_cin  <= (m_ready() == 2'b10) ? req1_cin : req0_cin;
            end
        end else if (m_age < W) begin
            m_age <= m_age + 1;
        end else if (rsp_ready) begin
            m_age <= -1;
        end
    end

    always @(negedge CLK) begin
        logic [1:0] er;
        int msk, c, tot;
        er = m_ready();
        chk("req0_ready", req0_ready, er[0]);
        chk("req1_ready", req1_ready, er[1]);
        chk("rsp_valid", rsp_valid, m_age == W);
        chk("busy", busy, m_age != -1);
        if (m_age >= 0 && m_age < W) begin
            msk = (1 << m_age) - 1;
            c   = ((int'(m_a) & msk) + (int'(m_b) & msk) + int'(m_cin)) >> m_age;
            chk("fa_a", fa_a, m_a[m_age]);
            chk("fa_b", fa_b, m_b[m_age]);
            chk("fa_cin", fa_cin, c & 1);
        end else begin
            chk("fa_idle", {fa_a, fa_b, fa_cin}, 0);
        end
        if (m_age == W) begin
            tot = int'(m_a) + int'(m_b) + int'(m_cin);
            chk("rsp_sum", rsp_sum, tot & 8'hFF);
            chk("rsp_cout", rsp_cout, (tot >> W) & 1);
            chk("rsp_id", rsp_id, m_id);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        NRST = 0; clr = 0; rsp_ready = 1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_cin = 0;
        req1_a = 0; req1_b = 0; req1_cin = 0;
        repeat (2) tick();
        NRST = 1;
    endtask

    task automatic send(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c);
        if (r) begin req1_valid = 1; req1_a = a; req1_b = b; req1_cin = c; end
        else   begin req0_valid = 1; req0_a = a; req0_b = b; req0_cin = c; end
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (r ? req1_ready : req0_ready) begin
                tick();
                if (r) req1_valid = 0; else req0_valid = 0;
                return;
            end
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            lat++;
            if (rsp_valid) return;
        end
        chk("rsp_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int lat, hs, nacc, cyc, prev;
        do_reset();
        @(negedge CLK);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_sum", rsp_sum, 0);
        chk("reset_rsp_cout", rsp_cout, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_busy", busy, 0);
        tick();

        // 1: single op, latency and literal result
        send(0, 8'h5A, 8'h33, 0);
        wait_rsp(lat);
        chk("t1_latency", lat, W + 1);
        chk("t1_sum", rsp_sum, 8'h8D);
        chk("t1_cout", rsp_cout, 0);
        chk("t1_id", rsp_id, 0);
        tick();

        // 2: contention right after reset, req0 first then req1
        do_reset();
        req1_valid = 1; req1_a = 8'hFF; req1_b = 8'h01; req1_cin = 1;
        send(0, 8'h12, 8'h34, 0);
        wait_rsp(lat);
        chk("t2_first_id", rsp_id, 0);
        chk("t2_first_sum", rsp_sum, 8'h46);
        tick();
        send(1, 8'hFF, 8'h01, 1);
        wait_rsp(lat);
        chk("t2_second_id", rsp_id, 1);
        chk("t2_second_sum", rsp_sum, 8'h01);
        chk("t2_second_cout", rsp_cout, 1);
        tick();

        // 3: response backpressure
        rsp_ready = 0;
        send(0, 8'h10, 8'h20, 1);
        req0_valid = 1; req1_valid = 1;
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge CLK);
            chk("t3_hold_valid", rsp_valid, 1);
            chk("t3_hold_sum", rsp_sum, 8'h31);
            chk("t3_hold_id", rsp_id, 0);
            chk("t3_readys", {req0_ready, req1_ready}, 0);
        end
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        hs = 0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid && rsp_ready) hs++;
            @(negedge CLK);
        end
        chk("t3_handshakes", hs, 1);
        tick();

        // 4: clr on the third RUN cycle aborts silently
        send(0, 8'h77, 8'h11, 0);
        tick(); tick();
        clr = 1;
        tick();
        clr = 0;
        @(negedge CLK);
        chk("t4_busy_after_clr", busy, 0);
        hs = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (rsp_valid) hs++;
        end
        chk("t4_no_rsp", hs, 0);
        tick();
        send(0, 8'h80, 8'h80, 0);
        wait_rsp(lat);
        chk("t4_sum", rsp_sum, 8'h00);
        chk("t4_cout", rsp_cout, 1);
        tick();

        // 5: async reset mid-RUN, then req0 wins contention
        send(1, 8'h0F, 8'hF0, 0);
        tick(); tick();
        #2 NRST = 0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_rsp_id", rsp_id, 0);
        chk("t5_rsp_sum", rsp_sum, 0);
        chk("t5_fa", {fa_a, fa_b, fa_cin}, 0);
        tick();
        NRST = 1;
        req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02; req0_cin = 0;
        req1_valid = 1; req1_a = 8'h03; req1_b = 8'h04; req1_cin = 0;
        @(negedge CLK);
        chk("t5_grant0", req0_ready, 1);
        chk("t5_nogrant1", req1_ready, 0);
        tick();
        req0_valid = 0;
        wait_rsp(lat);
        chk("t5_first_id", rsp_id, 0);
        tick();
        send(1, 8'h03, 8'h04, 0);
        wait_rsp(lat);
        chk("t5_second_sum", rsp_sum, 8'h07);
        tick();

        // 6: req1 continuously valid is accepted every W+2 cycles
        req1_valid = 1; req1_a = 8'hA5; req1_b = 8'h5A; req1_cin = 1;
        nacc = 0; prev = -1; cyc = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge CLK);
            if (req1_ready) begin
                if (prev >= 0) chk("t6_spacing", cyc - prev, W + 2);
                prev = cyc;
                nacc++;
            end
            cyc++;
        end
        chk("t6_accepts_min", nacc >= 4, 1);
        tick();
        req1_valid = 0;
        repeat (12) tick();

        // random traffic, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            req0_valid = ($urandom_range(0, 1) == 1);
            req1_valid = ($urandom_range(0, 1) == 1);
            req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
            req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 39) == 0);
            tick();
        end
        clr = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
